// File: rtl/mor_fsm_if.sv
// mor_fsm_if: serial detector bus, din (bit stream into detector) and y (detect flag out of detector)
interface mor_fsm_if;
  logic din;
  logic y;
  modport master(output din, input y);
  modport slave(input din, output y);
endinterface

// File: rtl/mor_fsm.sv
// mor_fsm: Moore "1010"-style sequence detector; clk, reset (sync active-low), bus.din serial in, bus.y registered match flag
module mor_fsm #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter bit OVERLAP = 1'b1
) (
  input logic clk,
  input logic reset,
  mor_fsm_if.slave bus
);
  localparam int SW = $clog2(PAT_LEN + 1);
  typedef enum logic [SW-1:0] {S0 = '0, SM = SW'(PAT_LEN)} state_t;
  function automatic int nxt(int k, logic d);
    int n, r;
    logic ok, b;
    n = (k == PAT_LEN && !OVERLAP) ? 0 : k;
    r = 0;
    for (int j = 1; j <= PAT_LEN; j++) if (j <= n + 1) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        b = (n + 1 - j + i == n) ? d : PATTERN[PAT_LEN - 1 - (n + 1 - j + i)];
        ok = ok & (b == PATTERN[PAT_LEN - 1 - i]);
      end
      r = ok ? j : r;
    end
    return r;
  endfunction
  logic [SW-1:0] tbl [2**(SW+1)];
  for (genvar s = 0; s < 2**SW; s++) begin : g_s
    for (genvar d = 0; d < 2; d++) begin : g_d
      assign tbl[s*2+d] = (s > PAT_LEN) ? '0 : SW'(nxt(s, 1'(d)));
    end
  end
  state_t state;
  always_ff @(posedge clk) begin
    state <= reset ? state_t'(tbl[{state, bus.din}]) : S0;
    bus.y <= reset && (tbl[{state, bus.din}] == SM);
  end
endmodule

// File: tb/tb_mor_fsm.sv
// tb_mor_fsm: directed checks of default, non-overlapping and 3-bit "110" detector variants
module tb_mor_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mor_fsm_if i0();
  mor_fsm_if i1();
  mor_fsm_if i2();
  mor_fsm u0 (.clk(clk), .reset(reset), .bus(i0.slave));
  mor_fsm #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset(reset), .bus(i1.slave));
  mor_fsm #(.PAT_LEN(3), .PATTERN(3'b110), .OVERLAP(1'b1)) u2 (.clk(clk), .reset(reset), .bus(i2.slave));
  task automatic chk(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic tick(input logic d);
    i0.din = d;
    i1.din = d;
    i2.din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input int n, input logic [15:0] d, input logic [15:0] e0,
                     input logic [15:0] e1, input logic [15:0] e2);
    for (int i = n - 1; i >= 0; i--) begin
      tick(d[i]);
      chk($sformatf("%s[%0d].u0", tag, n - 1 - i), i0.y, e0[i]);
      chk($sformatf("%s[%0d].u1", tag, n - 1 - i), i1.y, e1[i]);
      chk($sformatf("%s[%0d].u2", tag, n - 1 - i), i2.y, e2[i]);
    end
  endtask
  task automatic rst(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1'(i % 2));
      chk($sformatf("rst[%0d].u0", i), i0.y, 1'b0);
      chk($sformatf("rst[%0d].u1", i), i1.y, 1'b0);
      chk($sformatf("rst[%0d].u2", i), i2.y, 1'b0);
    end
    reset = 1'b1;
  endtask
  initial begin
    i0.din = 1'b0;
    i1.din = 1'b0;
    i2.din = 1'b0;
    rst(2);
    run("basic", 10, 16'b0111010101, 16'b0000001010, 16'b0000001000, 16'b0000100000);
    rst(1);
    run("chain", 6, 16'b101010, 16'b000101, 16'b000100, 16'b000000);
    rst(1);
    run("miss", 10, 16'b1001011011, 16'b0, 16'b0, 16'b0000000100);
    rst(1);
    run("mid_a", 3, 16'b101, 16'b0, 16'b0, 16'b0);
    rst(1);
    run("mid_b", 5, 16'b01010, 16'b00001, 16'b00001, 16'b0);
    rst(1);
    run("var", 7, 16'b1110110, 16'b0, 16'b0, 16'b0001001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mor_fsm.md
Name: mor_fsm

Overview:
- Moore-type serial sequence detector; default pattern "1010", overlapping detection.
- Samples one bit of `din` per rising edge of `clk`.
- Asserts `y` for exactly one clock cycle while the FSM is in the full-match state.
- Used as a standalone pattern-detect block on a single-bit serial stream; output is a function of state only (no combinational path `din` -> `y`).

Parameters:
- PAT_LEN, 4, pattern length in bits (2..8).
- PATTERN, 4'b1010, pattern to detect; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping detection (suffix of a match may start the next match); 0 = non-overlapping (restart after a match).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- din  input  1  serial data bit, sampled on rising edge of `clk`.
- y  output  1  detect flag; 1 only while in the full-match state.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset is sampled on the rising edge of `clk`. `reset`=0 forces state S0 and `y`=0 on that edge, regardless of `din`. It has priority over all transitions.
- Reset mid-sequence discards partial match progress.
- State S_k (k = 0..PAT_LEN) means the last k bits received equal the first k bits of PATTERN. k is the maximal such value.
- Encoding: binary, ceil(log2(PAT_LEN+1)) bits. Unused encodings go to S0 on the next edge.
- Output: `y` = 1 iff state == S_PAT_LEN. `y` is decoded from the state register only, with no dependence on `din`.
- Latency: `y` rises on the same clock edge that samples the final pattern bit. It stays high for exactly one cycle unless the next bit completes another match.
- Next-state rule from S_k, k < PAT_LEN:
  - Append `din`, giving a string of k+1 bits.
  - Next state is S_j, where j is the length of the longest suffix of that string that is also a prefix of PATTERN.
- From S_PAT_LEN:
  - OVERLAP=1: same rule as above, applied to the full matched pattern plus `din`.
  - OVERLAP=0: treat as S0, then apply the rule.
- Default transition table (PATTERN=1010, OVERLAP=1), shown as din=0 / din=1:
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S4 / S1
  - S4 (y=1): S0 / S3
- Same pattern with OVERLAP=0: S4 goes to S0 on din=0 and S1 on din=1.
- The transition function is computed generically from the parameters (a loop or generate block over PATTERN). It is not hard-coded.
- Before the first reset, state and `y` are undefined. Benches apply reset first.

Test Plan:
- Reset: hold `reset`=0 for 2 edges with `din` toggling -> `y`=0, state S0 throughout. Release `reset`=1 -> `y` stays 0 until a full pattern arrives.
- Basic detect: after reset, `din` per edge 0,1,1,1,0,1,0,1,0,1 -> `y`=1 only after the 7th edge (first "1010" complete) and after the 9th edge (overlap); `y`=0 after every other edge.
- Overlap chain: `din` 1,0,1,0,1,0 -> `y`=1 after edges 4 and 6, 0 elsewhere. Repeat with OVERLAP=0 -> `y`=1 after edge 4 only.
- Near-miss: `din` 1,0,0,1,0,1,1,0,1,1 -> `y` never asserts; state returns to S0 after each 0 that follows "10".
- Mid-sequence reset: `din` 1,0,1, then `reset`=0 for one edge, then `din` 0 -> `y`=0 (no detect); a subsequent 1,0,1,0 -> `y`=1 after the 4th bit.
- Parameter variant: PAT_LEN=3, PATTERN=3'b110, OVERLAP=1, `din` 1,1,1,0,1,1,0 -> `y`=1 after edges 4 and 7 only.
